// File: rtl/hex_button_counter.sv
// Three-button up/down/clear counter with per-button debounce and press-and-hold
// auto-repeat, feeding a 4-digit hex display with leading-zero blanking.

module hbc_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(CYCLES - 1);

  logic [1:0]   sync;
  logic [W-1:0] cnt;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level, so any bounce back to the old level restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= 2'b00;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt >= LIMIT) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module hbc_press #(
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       level,
  input  logic       clr,
  output logic       step,
  output logic [1:0] state
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam int RW = $clog2(REPEAT_PERIOD + 1);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_LIMIT  = RW'(REPEAT_PERIOD - 1);

  logic          level_q;
  logic          rise;
  logic [1:0]    state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [RW-1:0] rep_cnt, rep_n;

  assign rise = level & ~level_q;

  always_comb begin
    state_n = state;
    step    = 1'b0;
    hold_n  = hold_cnt;
    rep_n   = rep_cnt;
    case (state)
      IDLE: begin
        hold_n = '0;
        rep_n  = '0;
        if (rise) begin
          state_n = HOLD;
          step    = 1'b1;
        end
      end
      HOLD: begin
        if (!level) begin
          state_n = IDLE;
          hold_n  = '0;
        end else if (hold_cnt >= HOLD_LIMIT) begin
          state_n = REPEAT;
          step    = 1'b1;
          hold_n  = '0;
          rep_n   = '0;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!level) begin
          state_n = IDLE;
          rep_n   = '0;
        end else if (rep_cnt >= REP_LIMIT) begin
          step  = 1'b1;
          rep_n = '0;
        end else begin
          rep_n = rep_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // A held clear parks the FSM; a press edge seen during clear is dropped.
    if (clr) begin
      state_n = IDLE;
      step    = 1'b0;
      hold_n  = '0;
      rep_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      level_q  <= 1'b0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      state    <= state_n;
      level_q  <= level;
      hold_cnt <= hold_n;
      rep_cnt  <= rep_n;
    end
  end
endmodule

module hex_button_counter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_clr,
  output logic [15:0] value,
  output logic [7:0]  display_enable,
  output logic [3:0]  dbg_state
);
  logic       up_lvl, down_lvl, clr_lvl;
  logic       up_step, down_step;
  logic [1:0] up_state, down_state;
  logic [15:0] value_n;

  hbc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .reset(reset), .raw(btn_up), .level(up_lvl));
  hbc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .reset(reset), .raw(btn_down), .level(down_lvl));
  hbc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .reset(reset), .raw(btn_clr), .level(clr_lvl));

  hbc_press #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_press_up (
    .clk(clk), .reset(reset), .level(up_lvl), .clr(clr_lvl),
    .step(up_step), .state(up_state));
  hbc_press #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_press_down (
    .clk(clk), .reset(reset), .level(down_lvl), .clr(clr_lvl),
    .step(down_step), .state(down_state));

  assign dbg_state = {down_state, up_state};

  always_comb begin
    value_n = value;
    if (clr_lvl)                value_n = 16'h0000;
    else if (up_step && !down_step) value_n = value + 16'd1;
    else if (down_step && !up_step) value_n = value - 16'd1;
  end

  // display_enable is derived from value_n so both registers move together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value          <= 16'h0000;
      display_enable <= 8'h01;
    end else begin
      value          <= value_n;
      display_enable <= {4'b0000, |value_n[15:12], |value_n[15:8], |value_n[15:4], 1'b1};
    end
  end
endmodule

// File: tb/tb_hex_button_counter.sv
// Directed bench for hex_button_counter with short debounce/repeat parameters.

module tb_hex_button_counter;
  logic        clk;
  logic        reset;
  logic        btn_up, btn_down, btn_clr;
  logic [15:0] value;
  logic [7:0]  display_enable;
  logic [3:0]  dbg_state;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  hex_button_counter #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_clr(btn_clr),
    .value(value),
    .display_enable(display_enable),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic up, input logic down, input logic clr, input int n);
    btn_up = up; btn_down = down; btn_clr = clr;
    wait_cycles(n);
    btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    wait_cycles(15);
  endtask

  initial begin
    reset = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    wait_cycles(3);
    check("rst_value", value, 16'h0000);
    check("rst_de", {8'h00, display_enable}, 16'h0001);
    check("rst_state", {12'h000, dbg_state}, 16'h0000);
    reset = 1'b1;
    wait_cycles(20);
    check("idle_value", value, 16'h0000);
    check("idle_de", {8'h00, display_enable}, 16'h0001);

    // Bouncy press: only the stable 10-cycle stretch is accepted.
    btn_up = 1'b1; wait_cycles(3);
    btn_up = 1'b0; wait_cycles(2);
    btn_up = 1'b1; wait_cycles(3);
    btn_up = 1'b0; wait_cycles(2);
    press(1'b1, 1'b0, 1'b0, 10);
    check("glitch_value", value, 16'h0001);
    check("glitch_de", {8'h00, display_enable}, 16'h0001);

    press(1'b0, 1'b0, 1'b1, 8);
    check("clr_value", value, 16'h0000);

    // Down press with exact latency: 2 sync + 4 debounce edges, then one more.
    btn_down = 1'b1;
    wait_cycles(6);
    check("down_pre", value, 16'h0000);
    wait_cycles(1);
    check("down_step", value, 16'hFFFF);
    check("down_hold_state", {12'h000, dbg_state}, 16'h0004);
    press(1'b0, 1'b1, 1'b0, 1);
    check("wrap_down_value", value, 16'hFFFF);
    check("wrap_down_de", {8'h00, display_enable}, 16'h000F);
    press(1'b1, 1'b0, 1'b0, 8);
    check("wrap_up_value", value, 16'h0000);
    check("wrap_up_de", {8'h00, display_enable}, 16'h0001);

    // Auto-repeat: steps at +0, +20, +25, +30, +35 of a 38-cycle hold.
    btn_up = 1'b1;
    wait_cycles(30);
    check("repeat_mid_value", value, 16'h0002);
    check("repeat_mid_state", {12'h000, dbg_state}, 16'h0002);
    press(1'b1, 1'b0, 1'b0, 8);
    check("repeat_value", value, 16'h0005);
    check("repeat_de", {8'h00, display_enable}, 16'h0001);

    // Reach 0x00F0: 1213-cycle hold gives 2 + floor((1213-21)/5) = 240 steps.
    press(1'b0, 1'b0, 1'b1, 8);
    press(1'b1, 1'b0, 1'b0, 1213);
    check("f0_value", value, 16'h00F0);
    check("f0_de", {8'h00, display_enable}, 16'h0003);

    btn_up = 1'b1; btn_down = 1'b1;
    wait_cycles(7);
    check("simul_step", value, 16'h00F0);
    check("simul_state", {12'h000, dbg_state}, 16'h0005);
    press(1'b1, 1'b1, 1'b0, 1);
    check("simul_value", value, 16'h00F0);
    check("simul_de", {8'h00, display_enable}, 16'h0003);

    btn_clr = 1'b1; btn_up = 1'b1;
    wait_cycles(7);
    check("clr_up_value", value, 16'h0000);
    check("clr_up_de", {8'h00, display_enable}, 16'h0001);
    check("clr_up_state", {12'h000, dbg_state}, 16'h0000);
    press(1'b1, 1'b0, 1'b1, 1);
    check("clr_up_after", value, 16'h0000);

    // Reset in the middle of auto-repeat with the button still held.
    btn_up = 1'b1;
    wait_cycles(30);
    check("pre_rst_value", value, 16'h0002);
    check("pre_rst_state", {12'h000, dbg_state}, 16'h0002);
    reset = 1'b0;
    #1;
    check("mid_rst_value", value, 16'h0000);
    check("mid_rst_de", {8'h00, display_enable}, 16'h0001);
    check("mid_rst_state", {12'h000, dbg_state}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    wait_cycles(6);
    check("post_rst_pre", value, 16'h0000);
    wait_cycles(1);
    check("post_rst_step", value, 16'h0001);
    check("post_rst_state", {12'h000, dbg_state}, 16'h0001);
    press(1'b1, 1'b0, 1'b0, 2);
    check("post_rst_final", value, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
